// File: rtl/adc_channel_sampler.sv
// Samples one mux channel per switchSignal rising edge: settle, clock a serial ADC word in MSB-first, tag it with the channel.
// dataValid follows detection by SETTLE_CYCLES + 2*SCLK_DIV*ADC_BITS cycles; triggers arriving while busy are dropped and flagged on overrun.
module adc_channel_sampler #(
   parameter int SETTLE_CYCLES = 16,
   parameter int SCLK_DIV      = 2,
   parameter int ADC_BITS      = 12
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                switchSignal,
   input  logic [4:0]          cntChannel,
   input  logic                adcSdo,
   output logic                adcCs,
   output logic                adcSclk,
   output logic [ADC_BITS-1:0] dataOut,
   output logic [4:0]          chanOut,
   output logic                dataValid,
   output logic                busy,
   output logic                overrun
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      CONV   = 3'd2,
      DONE   = 3'd3,
      HOLD   = 3'd4
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] DIV_LAST    = 4'(SCLK_DIV - 1);
   localparam logic [4:0] BIT_LAST    = 5'(ADC_BITS - 1);

   state_t              state;
   logic                prev_sw;
   logic [7:0]          settle_cnt;
   logic [4:0]          bit_cnt;
   logic [3:0]          div_cnt;
   logic [ADC_BITS-1:0] shift_reg;
   logic [4:0]          chan_latch;
   logic                trigger;

   assign trigger = switchSignal & ~prev_sw;

   // prev_sw resets high so a level already high at reset release is not seen as an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         prev_sw    <= 1'b1;
         settle_cnt <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         shift_reg  <= '0;
         chan_latch <= '0;
         adcCs      <= 1'b1;
         adcSclk    <= 1'b1;
         dataOut    <= '0;
         chanOut    <= '0;
         dataValid  <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         prev_sw   <= switchSignal;
         dataValid <= 1'b0;
         overrun   <= trigger && (state != IDLE);
         case (state)
            IDLE: begin
               if (trigger) begin
                  state      <= SETTLE;
                  busy       <= 1'b1;
                  settle_cnt <= '0;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt + 8'd1;
               if (settle_cnt == SETTLE_LAST) begin
                  state      <= CONV;
                  adcCs      <= 1'b0;
                  adcSclk    <= 1'b0;
                  chan_latch <= cntChannel;
                  bit_cnt    <= '0;
                  div_cnt    <= '0;
               end
            end
            CONV: begin
               // Each bit: SCLK_DIV cycles low, then SCLK_DIV cycles high; sample on the rising transition.
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!adcSclk) begin
                     adcSclk   <= 1'b1;
                     shift_reg <= {shift_reg[ADC_BITS-2:0], adcSdo};
                  end else if (bit_cnt == BIT_LAST) begin
                     state     <= DONE;
                     adcCs     <= 1'b1;
                     dataOut   <= shift_reg;
                     chanOut   <= chan_latch;
                     dataValid <= 1'b1;
                  end else begin
                     adcSclk <= 1'b0;
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + 4'd1;
               end
            end
            DONE: begin
               state <= HOLD;
            end
            HOLD: begin
               if (!switchSignal) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               adcCs   <= 1'b1;
               adcSclk <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_channel_sampler.sv
// Scoreboarded bench for adc_channel_sampler with a behavioural MSB-first serial ADC.
module tb_adc_channel_sampler;

   localparam int S   = 4;
   localparam int D   = 2;
   localparam int B   = 12;
   localparam int LAT = S + 2 * D * B;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          switchSignal = 1'b0;
   logic [4:0]    cntChannel = 5'd0;
   logic          adcSdo = 1'b0;
   logic          adcCs;
   logic          adcSclk;
   logic [B-1:0]  dataOut;
   logic [4:0]    chanOut;
   logic          dataValid;
   logic          busy;
   logic          overrun;

   adc_channel_sampler #(.SETTLE_CYCLES(S), .SCLK_DIV(D), .ADC_BITS(B)) dut (
      .clk(clk), .reset(reset), .switchSignal(switchSignal), .cntChannel(cntChannel),
      .adcSdo(adcSdo), .adcCs(adcCs), .adcSclk(adcSclk), .dataOut(dataOut),
      .chanOut(chanOut), .dataValid(dataValid), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int data;
      int chan;
      int cyc;
   } exp_t;

   exp_t   sb[$];
   int     tests = 0;
   int     fails = 0;
   int     cyc = 0;
   int     cs_low_cnt = 0;
   int     rise_cnt = 0;
   int     ov_cnt = 0;
   int     ov_cyc = 0;
   int     dv_cnt = 0;
   logic [B-1:0] adc_word = '0;
   int     bit_idx = 0;

   task automatic check(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // ADC model: shifts out the next bit on each falling sclk, restarts when CS deasserts.
   always @(negedge adcSclk) begin
      if (bit_idx < B) adcSdo = adc_word[B-1-bit_idx];
      bit_idx = bit_idx + 1;
   end
   always @(posedge adcCs) bit_idx = 0;

   always @(posedge adcSclk) if (adcCs === 1'b0) rise_cnt++;

   always @(negedge clk) begin
      if (adcCs === 1'b0) cs_low_cnt++;
      if (overrun === 1'b1) begin
         ov_cnt++;
         ov_cyc = cyc;
      end
      if (dataValid === 1'b1) begin
         dv_cnt++;
         check("dv_expected", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("dv_data", int'(dataOut), e.data);
            check("dv_chan", int'(chanOut), e.chan);
            check("dv_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic clear_counts();
      cs_low_cnt = 0;
      rise_cnt   = 0;
      ov_cnt     = 0;
      dv_cnt     = 0;
   endtask

   // Raises switchSignal at a negedge; the following posedge is the detection edge.
   task automatic raise_trigger(input logic [B-1:0] word, input logic [4:0] chan, input bit expect_dv,
                                input int exp_chan);
      @(negedge clk);
      adc_word     = word;
      cntChannel   = chan;
      switchSignal = 1'b1;
      if (expect_dv) sb.push_back('{int'(word), exp_chan, cyc + 1 + LAT});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cs", int'(adcCs), 1);
      check("rst_sclk", int'(adcSclk), 1);
      check("rst_data", int'(dataOut), 0);
      check("rst_chan", int'(chanOut), 0);
      check("rst_dv", int'(dataValid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ovr", int'(overrun), 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Nominal conversion
      clear_counts();
      raise_trigger(12'hA5C, 5'd5, 1'b1, 5);
      repeat (3) @(negedge clk);
      check("nom_busy", int'(busy), 1);
      repeat (7) @(negedge clk);
      switchSignal = 1'b0;
      repeat (60) @(negedge clk);
      check("nom_cs_low", cs_low_cnt, 48);
      check("nom_sclk_rises", rise_cnt, 12);
      check("nom_dv_cnt", dv_cnt, 1);
      check("nom_ovr_cnt", ov_cnt, 0);
      check("nom_busy_end", int'(busy), 0);
      check("nom_hold_data", int'(dataOut), 12'hA5C);

      // Channel latched only at SETTLE->CONV
      clear_counts();
      raise_trigger(12'h3C1, 5'd16, 1'b1, 17);
      repeat (2) @(negedge clk);
      cntChannel = 5'd17;
      repeat (13) @(negedge clk);
      cntChannel = 5'd0;
      switchSignal = 1'b0;
      repeat (50) @(negedge clk);
      check("lat_dv_cnt", dv_cnt, 1);
      check("lat_hold_chan", int'(chanOut), 17);

      // Overrun: second edge 10 cycles into CONV
      clear_counts();
      raise_trigger(12'h5A3, 5'd3, 1'b1, 3);
      begin
         int t0;
         t0 = cyc;
         repeat (3) @(negedge clk);
         switchSignal = 1'b0;
         repeat (12) @(negedge clk);
         switchSignal = 1'b1;
         repeat (5) @(negedge clk);
         switchSignal = 1'b0;
         repeat (50) @(negedge clk);
         check("ovr_cnt", ov_cnt, 1);
         check("ovr_cycle", ov_cyc, t0 + 16);
         check("ovr_dv_cnt", dv_cnt, 1);
         check("ovr_cs_low", cs_low_cnt, 48);
         check("ovr_busy_end", int'(busy), 0);
      end

      // Reset during bit 6 of CONV
      clear_counts();
      raise_trigger(12'hFFF, 5'd9, 1'b0, 0);
      repeat (30) @(negedge clk);
      check("abort_cs_before", int'(adcCs), 0);
      check("abort_sclk_before", int'(adcSclk), 0);
      reset = 1'b0;
      #1;
      check("abort_cs_async", int'(adcCs), 1);
      check("abort_sclk_async", int'(adcSclk), 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      clear_counts();
      repeat (80) @(negedge clk);
      check("abort_dv_cnt", dv_cnt, 0);
      check("abort_no_conv", cs_low_cnt, 0);
      check("abort_data_clr", int'(dataOut), 0);
      check("abort_busy", int'(busy), 0);
      switchSignal = 1'b0;
      repeat (3) @(negedge clk);
      raise_trigger(12'h123, 5'd9, 1'b1, 9);
      repeat (5) @(negedge clk);
      switchSignal = 1'b0;
      repeat (60) @(negedge clk);
      check("rearm_dv_cnt", dv_cnt, 1);

      // Back-to-back 64-cycle periods over channels 0..17
      clear_counts();
      for (int i = 0; i < 18; i++) begin
         raise_trigger(12'(i * 227 + 100), 5'(i), 1'b1, i);
         repeat (32) @(negedge clk);
         switchSignal = 1'b0;
         repeat (31) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("b2b_dv_cnt", dv_cnt, 18);
      check("b2b_ovr_cnt", ov_cnt, 0);
      check("b2b_last_chan", int'(chanOut), 17);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
